// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Round-robin arbiter that shares one register-file write port
//            between an execute (A) and a load (B) writeback requester.
//            Writes to x0 are accepted but never strobed; arbitration
//            conflicts are counted with a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [ADDR_WIDTH-1:0] a_address,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [ADDR_WIDTH-1:0] b_address,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  enable_write,
   output logic [ADDR_WIDTH-1:0] write_address,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  prio,
   output logic [CNT_WIDTH-1:0]  conflict_count
);

   localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                  r_enable_write;
   logic [ADDR_WIDTH-1:0] r_write_address;
   logic [DATA_WIDTH-1:0] r_write_data;
   logic                  r_prio;
   logic [CNT_WIDTH-1:0]  r_conflict_count;

   logic                  w_grant_a;
   logic                  w_grant_b;
   logic                  w_conflict;

   // Grant decode: a lone requester always wins, a conflict goes to the
   // side named by the priority pointer. No grant is issued while reset
   // is asserted so nothing is accepted that would then be lost.
   always_comb begin
      w_conflict = a_valid & b_valid;
      w_grant_a  = rst & a_valid & (~b_valid | ~r_prio);
      w_grant_b  = rst & b_valid & (~a_valid |  r_prio);
   end

   // Register the granted write; x0 targets are accepted but not strobed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_enable_write  <= 1'b0;
         r_write_address <= '0;
         r_write_data    <= '0;
      end else if (w_grant_a) begin
         r_enable_write  <= |a_address;
         r_write_address <= a_address;
         r_write_data    <= a_data;
      end else if (w_grant_b) begin
         r_enable_write  <= |b_address;
         r_write_address <= b_address;
         r_write_data    <= b_data;
      end else begin
         r_enable_write  <= 1'b0;
      end
   end

   // Priority pointer moves to the side that was not granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prio <= 1'b0;
      end else if (w_grant_a) begin
         r_prio <= 1'b1;
      end else if (w_grant_b) begin
         r_prio <= 1'b0;
      end
   end

   // Saturating count of cycles in which both requesters were valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_conflict_count <= '0;
      end else if (w_conflict && (r_conflict_count != c_cnt_max)) begin
         r_conflict_count <= r_conflict_count + c_cnt_one;
      end
   end

   assign a_ready        = w_grant_a;
   assign b_ready        = w_grant_b;
   assign enable_write   = r_enable_write;
   assign write_address  = r_write_address;
   assign write_data     = r_write_data;
   assign prio           = r_prio;
   assign conflict_count = r_conflict_count;

endmodule
`default_nettype wire
